// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM stage of the 5-stage MIPS pipeline. It registers the EXE
//             payload, extracts load data from the synchronous data SRAM, and
//             feeds the WB bus and the forwarding/hazard outputs. Read data
//             is captured during multi-cycle stalls so the result stays stable.
//  Options  : MS_ALIGN_CHK_EN enables the misaligned-load check (ms_ale).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 76,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [9:0]                 es_to_ms_addr,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [9:0]                 ms_to_ws_addr,
    input  logic [31:0]                data_sram_rdata,
    input  logic [1:0]                 stallM,
    output logic [31:0]                ms_forward,
    output logic [4:0]                 ms_dest,
    output logic                       ms_gr_we_tohazard,
    output logic                       ms_valid_tohazard,
    output logic                       ms_ale
);

    localparam logic [1:0] c_STALL_HOLD  = 2'b01;
    localparam logic [1:0] c_STALL_FLUSH = 2'b10;

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_es_to_ms_bus;
    logic [9:0]                 r_ms_addr;
    logic                       r_hold_vld;
    logic [31:0]                r_hold_data;

    logic        w_ld_w;
    logic        w_ld_h;
    logic        w_ld_b;
    logic        w_ld_sign;
    logic [1:0]  w_whb;
    logic        w_gr_we;
    logic        w_gr_we_eff;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_res;
    logic [31:0] w_pc;
    logic [31:0] w_rdata_eff;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_final_result;

    assign {w_ld_w, w_ld_h, w_ld_b, w_ld_sign, w_whb, w_gr_we,
            w_dest, w_alu_res, w_pc} = r_es_to_ms_bus;

    // The stage always completes in one cycle; only stallM and WB back-pressure block it.
    always_comb begin
        ms_allowin     = !r_ms_valid || ws_allowin;
        ms_to_ws_valid = r_ms_valid;
        if (stallM == c_STALL_HOLD) begin
            ms_allowin     = 1'b0;
            ms_to_ws_valid = 1'b0;
        end else if (stallM == c_STALL_FLUSH) begin
            ms_allowin     = 1'b1;
            ms_to_ws_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid     <= 1'b0;
            r_es_to_ms_bus <= '0;
            r_ms_addr      <= '0;
            r_hold_vld     <= 1'b0;
            r_hold_data    <= '0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
                if (es_to_ms_valid) begin
                    r_es_to_ms_bus <= es_to_ms_bus;
                    r_ms_addr      <= es_to_ms_addr;
                end
            end
            // SRAM data is only valid in the first MEM cycle; keep it if we stall past it.
            if (ms_allowin) begin
                r_hold_vld <= 1'b0;
            end else if (r_ms_valid && !r_hold_vld) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= data_sram_rdata;
            end
        end
    end

    always_comb begin
        w_rdata_eff = r_hold_vld ? r_hold_data : data_sram_rdata;
        w_half      = w_whb[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];
        case (w_whb)
            2'd0:    w_byte = w_rdata_eff[7:0];
            2'd1:    w_byte = w_rdata_eff[15:8];
            2'd2:    w_byte = w_rdata_eff[23:16];
            default: w_byte = w_rdata_eff[31:24];
        endcase
        if (w_ld_w) begin
            w_final_result = w_rdata_eff;
        end else if (w_ld_h) begin
            w_final_result = {{16{w_ld_sign & w_half[15]}}, w_half};
        end else if (w_ld_b) begin
            w_final_result = {{24{w_ld_sign & w_byte[7]}}, w_byte};
        end else begin
            w_final_result = w_alu_res;
        end
    end

`ifdef MS_ALIGN_CHK_EN
    assign ms_ale      = r_ms_valid & ((w_ld_w & (w_whb != 2'd0)) | (w_ld_h & w_whb[0]));
    assign w_gr_we_eff = w_gr_we & ~ms_ale;
`else
    assign ms_ale      = 1'b0;
    assign w_gr_we_eff = w_gr_we;
`endif

    assign ms_to_ws_bus      = {w_gr_we_eff, w_dest, w_final_result, w_pc};
    assign ms_to_ws_addr     = r_ms_addr;
    assign ms_forward        = w_final_result;
    assign ms_dest           = w_dest;
    assign ms_gr_we_tohazard = w_gr_we_eff & r_ms_valid;
    assign ms_valid_tohazard = r_ms_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: instruction-level model plus
//             hand-computed literal expectations on directed load sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

`ifdef MS_ALIGN_CHK_EN
    localparam bit c_ALE_EN = 1'b1;
`else
    localparam bit c_ALE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic [9:0]  es_to_ms_addr;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [9:0]  ms_to_ws_addr;
    logic [31:0] data_sram_rdata;
    logic [1:0]  stallM;
    logic [31:0] ms_forward;
    logic [4:0]  ms_dest;
    logic        ms_gr_we_tohazard;
    logic        ms_valid_tohazard;
    logic        ms_ale;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_to_ms_addr     (es_to_ms_addr),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ws_addr     (ms_to_ws_addr),
        .data_sram_rdata   (data_sram_rdata),
        .stallM            (stallM),
        .ms_forward        (ms_forward),
        .ms_dest           (ms_dest),
        .ms_gr_we_tohazard (ms_gr_we_tohazard),
        .ms_valid_tohazard (ms_valid_tohazard),
        .ms_ale            (ms_ale)
    );

    always #5 clk = ~clk;

    function automatic logic [75:0] mk(input logic w, input logic h, input logic b,
                                       input logic s, input logic [1:0] whb, input logic we,
                                       input logic [4:0] dest, input logic [31:0] alu,
                                       input logic [31:0] pc);
        return {w, h, b, s, whb, we, dest, alu, pc};
    endfunction

    // Load semantics stated arithmetically: shift the addressed lane down, mask, extend.
    function automatic logic [31:0] load_value(input logic [75:0] bus, input logic [31:0] rd);
        logic [31:0] v;
        int          sh;
        sh = int'(bus[71:70]) * 8;
        if (bus[75]) return rd;
        if (bus[74]) begin
            v = (rd >> (bus[71] ? 16 : 0)) & 32'h0000FFFF;
            if (bus[72] && v[15]) v = v | 32'hFFFF0000;
            return v;
        end
        if (bus[73]) begin
            v = (rd >> sh) & 32'h000000FF;
            if (bus[72] && v[7]) v = v | 32'hFFFFFF00;
            return v;
        end
        return bus[63:32];
    endfunction

    function automatic logic misaligned(input logic [75:0] bus);
        return (bus[75] && bus[71:70] != 2'd0) || (bus[74] && bus[70]);
    endfunction

    // Model: which instruction occupies MEM, and the SRAM word it saw on its first MEM cycle.
    logic        m_started = 1'b0;
    logic        m_valid   = 1'b0;
    logic [75:0] m_bus     = '0;
    logic [9:0]  m_addr    = '0;
    logic        m_first   = 1'b1;
    logic [31:0] m_data    = '0;

    function automatic logic exp_allowin();
        if (stallM == 2'b01) return 1'b0;
        if (stallM == 2'b10) return 1'b1;
        return !m_valid || ws_allowin;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_started = 1'b1;
            m_valid   = 1'b0;
            m_bus     = '0;
            m_addr    = '0;
            m_first   = 1'b1;
        end else if (m_started) begin
            if (exp_allowin()) begin
                m_valid = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    m_bus  = es_to_ms_bus;
                    m_addr = es_to_ms_addr;
                end
                m_first = 1'b1;
            end else if (m_valid && m_first) begin
                m_data  = data_sram_rdata;
                m_first = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            logic [31:0] e_res;
            logic        e_ale;
            logic        e_we;
            logic        e_ws_valid;
            e_res      = load_value(m_bus, m_first ? data_sram_rdata : m_data);
            e_ale      = c_ALE_EN && m_valid && misaligned(m_bus);
            e_we       = m_bus[69] && !e_ale;
            e_ws_valid = m_valid && stallM != 2'b01 && stallM != 2'b10;
            chk("ms_allowin", 70'(ms_allowin), 70'(exp_allowin()));
            chk("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(e_ws_valid));
            chk("ms_valid_tohazard", 70'(ms_valid_tohazard), 70'(m_valid));
            chk("ms_gr_we_tohazard", 70'(ms_gr_we_tohazard), 70'(e_we && m_valid));
            chk("ms_ale", 70'(ms_ale), 70'(e_ale));
            if (m_valid) begin
                chk("ms_forward", 70'(ms_forward), 70'(e_res));
                chk("ms_dest", 70'(ms_dest), 70'(m_bus[68:64]));
            end
            if (e_ws_valid) begin
                chk("ms_to_ws_bus", ms_to_ws_bus, {e_we, m_bus[68:64], e_res, m_bus[31:0]});
                chk("ms_to_ws_addr", 70'(ms_to_ws_addr), 70'(m_addr));
            end
        end
    end

    task automatic set_in(input logic ev, input logic [75:0] b, input logic [9:0] a,
                          input logic [31:0] rd, input logic wsa, input logic [1:0] st);
        es_to_ms_valid  = ev;
        es_to_ms_bus    = b;
        es_to_ms_addr   = a;
        data_sram_rdata = rd;
        ws_allowin      = wsa;
        stallM          = st;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [75:0] lw0, lh_s, lhu, lbu, lb_s, alu_de, lw_st, alu_55, lw_33, lw_fl, alu_77, lw_ho, lw_mis;

    initial begin
        lw0    = mk(1, 0, 0, 0, 2'b00, 1, 5'd3,  32'h0000_0100, 32'h0000_1000);
        lh_s   = mk(0, 1, 0, 1, 2'b10, 1, 5'd4,  32'h0000_0102, 32'h0000_1004);
        lhu    = mk(0, 1, 0, 0, 2'b10, 1, 5'd5,  32'h0000_0106, 32'h0000_1008);
        lbu    = mk(0, 0, 1, 0, 2'b11, 1, 5'd6,  32'h0000_0107, 32'h0000_100C);
        lb_s   = mk(0, 0, 1, 1, 2'b01, 1, 5'd7,  32'h0000_0109, 32'h0000_1010);
        alu_de = mk(0, 0, 0, 0, 2'b00, 1, 5'd8,  32'hDEAD_BEEF, 32'h0000_1014);
        lw_st  = mk(1, 0, 0, 0, 2'b00, 1, 5'd9,  32'h0000_0200, 32'h0000_1018);
        alu_55 = mk(0, 0, 0, 0, 2'b00, 1, 5'd10, 32'h0000_0055, 32'h0000_101C);
        lw_33  = mk(1, 0, 0, 0, 2'b00, 1, 5'd11, 32'h0000_0300, 32'h0000_1020);
        lw_fl  = mk(1, 0, 0, 0, 2'b00, 1, 5'd12, 32'h0000_0400, 32'h0000_1024);
        alu_77 = mk(0, 0, 0, 0, 2'b00, 0, 5'd13, 32'h0000_0077, 32'h0000_1028);
        lw_ho  = mk(1, 0, 0, 0, 2'b00, 1, 5'd14, 32'h0000_0500, 32'h0000_102C);
        lw_mis = mk(1, 0, 0, 0, 2'b10, 1, 5'd15, 32'h0000_0602, 32'h0000_1030);

        reset = 1'b1;
        set_in(0, '0, '0, '0, 1, 2'b00);
        tick();
        tick();
        reset = 1'b0;
        set_in(0, '0, '0, 32'h1234_5678, 1, 2'b00);
        chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("rst_allowin", 70'(ms_allowin), 70'd1);
        chk("rst_forward", 70'(ms_forward), 70'd0);
        chk("rst_ale", 70'(ms_ale), 70'd0);
        tick();

        set_in(1, lw0, 10'h061, 32'h0, 1, 2'b00);
        tick();
        set_in(1, lh_s, 10'h082, 32'h8899_AABB, 1, 2'b00);
        chk("lw_result", 70'(ms_to_ws_bus[63:32]), 70'h8899_AABB);
        chk("lw_gr_we", 70'(ms_to_ws_bus[69]), 70'd1);
        chk("lw_valid", 70'(ms_to_ws_valid), 70'd1);
        tick();
        set_in(1, lhu, 10'h0A3, 32'h8001_1234, 1, 2'b00);
        chk("lh_sign", 70'(ms_to_ws_bus[63:32]), 70'hFFFF_8001);
        tick();
        set_in(1, lbu, 10'h0C4, 32'h8001_1234, 1, 2'b00);
        chk("lhu", 70'(ms_to_ws_bus[63:32]), 70'h0000_8001);
        tick();
        set_in(1, lb_s, 10'h0E5, 32'hA512_3456, 1, 2'b00);
        chk("lbu", 70'(ms_to_ws_bus[63:32]), 70'h0000_00A5);
        tick();
        set_in(1, alu_de, 10'h106, 32'h0000_F000, 1, 2'b00);
        chk("lb_sign", 70'(ms_to_ws_bus[63:32]), 70'hFFFF_FFF0);
        tick();
        set_in(1, lw_st, 10'h127, 32'hFFFF_FFFF, 1, 2'b00);
        chk("alu_pass", 70'(ms_forward), 70'hDEAD_BEEF);
        tick();

        // Three-cycle WB back-pressure; SRAM output moves on after the first cycle.
        set_in(1, alu_55, 10'h148, 32'h1111_1111, 0, 2'b00);
        chk("stall_c1", 70'(ms_to_ws_bus[63:32]), 70'h1111_1111);
        chk("stall_allowin", 70'(ms_allowin), 70'd0);
        tick();
        set_in(1, alu_55, 10'h148, 32'h2222_2222, 0, 2'b00);
        chk("stall_c2", 70'(ms_to_ws_bus[63:32]), 70'h1111_1111);
        tick();
        set_in(1, alu_55, 10'h148, 32'h2222_2222, 0, 2'b00);
        chk("stall_c3", 70'(ms_forward), 70'h1111_1111);
        tick();
        set_in(1, alu_55, 10'h148, 32'h2222_2222, 1, 2'b00);
        chk("stall_handoff", 70'(ms_to_ws_bus[63:32]), 70'h1111_1111);
        chk("stall_handoff_v", 70'(ms_to_ws_valid), 70'd1);
        tick();
        set_in(1, lw_33, 10'h169, 32'h2222_2222, 1, 2'b00);
        chk("after_stall", 70'(ms_forward), 70'h0000_0055);
        tick();
        set_in(1, lw_fl, 10'h18A, 32'h3333_3333, 1, 2'b00);
        chk("hold_cleared", 70'(ms_to_ws_bus[63:32]), 70'h3333_3333);
        tick();

        set_in(1, alu_77, 10'h1AB, 32'h4444_4444, 0, 2'b10);
        chk("flush_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("flush_allowin", 70'(ms_allowin), 70'd1);
        tick();
        set_in(1, lw_ho, 10'h1CC, 32'h0, 1, 2'b00);
        chk("after_flush", 70'(ms_to_ws_bus[63:32]), 70'h0000_0077);
        chk("after_flush_we", 70'(ms_gr_we_tohazard), 70'd0);
        tick();

        set_in(1, alu_de, 10'h1ED, 32'hCAFE_F00D, 1, 2'b01);
        chk("hold_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("hold_allowin", 70'(ms_allowin), 70'd0);
        tick();
        set_in(0, '0, '0, 32'h0BAD_0BAD, 1, 2'b00);
        chk("hold_result", 70'(ms_to_ws_bus[63:32]), 70'hCAFE_F00D);
        tick();

        set_in(1, lw0, 10'h20E, 32'h0, 1, 2'b00);
        tick();
        reset = 1'b1;
        set_in(0, '0, '0, 32'h0, 1, 2'b01);
        tick();
        reset = 1'b0;
        set_in(0, '0, '0, 32'h0, 1, 2'b00);
        chk("rst_over_hold", 70'(ms_valid_tohazard), 70'd0);
        tick();

        set_in(1, lw_mis, 10'h22F, 32'h0, 1, 2'b00);
        tick();
        set_in(0, '0, '0, 32'h5566_7788, 1, 2'b00);
`ifdef MS_ALIGN_CHK_EN
        chk("ale_flag", 70'(ms_ale), 70'd1);
        chk("ale_gr_we", 70'(ms_to_ws_bus[69]), 70'd0);
`else
        chk("ale_flag", 70'(ms_ale), 70'd0);
        chk("ale_gr_we", 70'(ms_to_ws_bus[69]), 70'd1);
`endif
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
